// File: rtl/sos_control_module.sv
// sos_control_module: plays the Morse letters S, O, S by driving the S and O
// generators in turn. An inter-letter silence of GAP_MS milliseconds sits between letters.
// Latency: Trig rise -> S_Start_Sig is 2 cycles (edge detect, then S1 raises start).
//   Done in -> Start drop is 1 cycle. Each gap is exactly GAP_MS*(T1MS+1) cycles.
// Backpressure: none. Level starts are held until the matching one-cycle done arrives.
//   A Trig rise while busy is dropped, not queued.
// Optional feature: define SOS_ABORT_EN to add Abort_Sig. It cancels a running
//   sequence without a Done_Sig pulse.
module sos_control_module #(
  parameter logic [16:0] T1MS   = 17'd49_999,  // cycles per 1 ms tick minus one
  parameter logic [9:0]  GAP_MS = 10'd150      // inter-letter silence in ms
) (
  input  logic CLK,
  input  logic RSTn,          // synchronous, active-high despite the name
  input  logic Trig,
  input  logic S_Done_Sig,
  input  logic O_Done_Sig,
  input  logic S_Pin_In,
  input  logic O_Pin_In,
`ifdef SOS_ABORT_EN
  input  logic Abort_Sig,
`endif
  output logic S_Start_Sig,
  output logic O_Start_Sig,
  output logic Busy,
  output logic Done_Sig,
  output logic Pin_Out
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_GAP1 = 3'd2,
    ST_O    = 3'd3,
    ST_GAP2 = 3'd4,
    ST_S2   = 3'd5,
    ST_FIN  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic        trig_hist_q, trig_hist_d;
  logic        s_start_q, s_start_d;
  logic        o_start_q, o_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [16:0] pre_q, pre_d;
  logic [9:0]  ms_q, ms_d;

  logic        trig_rise;
  logic        pre_last;
  logic [9:0]  ms_inc;
  logic        gap_end;
  logic        abort_req;

  // Trig edge detect against last cycle's sample; gap timebase helpers
  always_comb begin
    trig_hist_d = Trig;
    trig_rise   = Trig & ~trig_hist_q;
    pre_last    = (pre_q == T1MS);
    ms_inc      = ms_q + 10'd1;
    // Last cycle of a gap: the final prescaler tick carries the ms count to GAP_MS
    gap_end     = pre_last && (ms_inc == GAP_MS);
  end

`ifdef SOS_ABORT_EN
  // Abort only matters once a sequence is under way
  always_comb begin
    abort_req = Abort_Sig && (state_q != ST_IDLE);
  end
`else
  // Without the abort feature every sequence runs to completion
  always_comb begin
    abort_req = 1'b0;
  end
`endif

  // Next-state and registered-output logic for the S-O-S sequencer
  always_comb begin
    state_d   = state_q;
    s_start_d = s_start_q;
    o_start_d = o_start_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pre_d     = '0;   // counters only run inside gap states, so they are zero on gap entry
    ms_d      = '0;

    case (state_q)
      ST_IDLE: begin
        s_start_d = 1'b0;
        o_start_d = 1'b0;
        busy_d    = 1'b0;
        if (trig_rise) begin
          state_d = ST_S1;
          busy_d  = 1'b1;
        end
      end

      // The start is dropped on the edge after done, so the generator idles instead of replaying
      ST_S1: begin
        o_start_d = 1'b0;
        if (S_Done_Sig) begin
          s_start_d = 1'b0;
          state_d   = ST_GAP1;
        end else begin
          s_start_d = 1'b1;
        end
      end

      // Gap exit loads the next start directly, so the line is silent for exactly the counted gap
      ST_GAP1: begin
        s_start_d = 1'b0;
        o_start_d = 1'b0;
        if (gap_end) begin
          state_d   = ST_O;
          o_start_d = 1'b1;
        end else begin
          pre_d = pre_last ? 17'd0 : pre_q + 17'd1;
          ms_d  = pre_last ? ms_inc : ms_q;
        end
      end

      ST_O: begin
        s_start_d = 1'b0;
        if (O_Done_Sig) begin
          o_start_d = 1'b0;
          state_d   = ST_GAP2;
        end else begin
          o_start_d = 1'b1;
        end
      end

      ST_GAP2: begin
        s_start_d = 1'b0;
        o_start_d = 1'b0;
        if (gap_end) begin
          state_d   = ST_S2;
          s_start_d = 1'b1;
        end else begin
          pre_d = pre_last ? 17'd0 : pre_q + 17'd1;
          ms_d  = pre_last ? ms_inc : ms_q;
        end
      end

      // Done_Sig is registered on entry to FIN, so it is high for exactly the FIN cycle
      ST_S2: begin
        o_start_d = 1'b0;
        if (S_Done_Sig) begin
          s_start_d = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_FIN;
        end else begin
          s_start_d = 1'b1;
        end
      end

      ST_FIN: begin
        s_start_d = 1'b0;
        o_start_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        s_start_d = 1'b0;
        o_start_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase

    // Abort wins over any same-cycle done and leaves without a completion pulse
    if (abort_req) begin
      state_d   = ST_IDLE;
      s_start_d = 1'b0;
      o_start_d = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      pre_d     = '0;
      ms_d      = '0;
    end
  end

  // State and output registers with synchronous active-high reset
  always_ff @(posedge CLK) begin
    if (RSTn) begin
      state_q     <= ST_IDLE;
      trig_hist_q <= 1'b0;
      s_start_q   <= 1'b0;
      o_start_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pre_q       <= '0;
      ms_q        <= '0;
    end else begin
      state_q     <= state_d;
      trig_hist_q <= trig_hist_d;
      s_start_q   <= s_start_d;
      o_start_q   <= o_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pre_q       <= pre_d;
      ms_q        <= ms_d;
    end
  end

  assign S_Start_Sig = s_start_q;
  assign O_Start_Sig = o_start_q;
  assign Busy        = busy_q;
  assign Done_Sig    = done_q;
  // Both pins are active-low, so either generator pulling low drives the line
  assign Pin_Out     = S_Pin_In & O_Pin_In;

endmodule

// File: doc/sos_control_module.md
Name: sos_control_module

Overview:
- Sequencer that sits directly upstream of the S and O Morse letter generators.
- On a trigger it plays S, O, S in order: it drives each generator's Start_Sig and waits for that generator's one-cycle Done_Sig.
- It inserts an inter-letter gap between letters and merges the generators' active-low pin outputs into one buzzer/LED line.
- It reports busy while playing and pulses done at the end.

Parameters:
- T1MS, 17'd49_999, clock cycles per 1 ms tick minus one (50 MHz clock).
- GAP_MS, 10'd150, inter-letter silence in ms.

Ports:
- CLK  input  1  system clock.
- RSTn  input  1  reset. Synchronous, active-high despite the name: RSTn=1 at a CLK rising edge resets the block.
- Trig  input  1  level request; a 0->1 transition, detected on a registered copy, starts one SOS.
- S_Done_Sig  input  1  one-cycle done pulse from the S generator.
- O_Done_Sig  input  1  one-cycle done pulse from the O generator.
- S_Pin_In  input  1  S generator pin; active-low, idle 1.
- O_Pin_In  input  1  O generator pin; active-low, idle 1.
- S_Start_Sig  output  1  level start to the S generator.
- O_Start_Sig  output  1  level start to the O generator.
- Busy  output  1  high from the start of S1 until the Done_Sig pulse.
- Done_Sig  output  1  one-cycle pulse when SOS completes.
- Pin_Out  output  1  S_Pin_In & O_Pin_In; combinational, active-low.

Behaviour:
- Reset values: S_Start_Sig=0, O_Start_Sig=0, Busy=0, Done_Sig=0, state IDLE, prescaler=0, ms counter=0, Trig history register=0.
- Edge detect: rise = Trig & !Trig_d, where Trig_d is registered every cycle.
- State sequence: IDLE -> S1 -> GAP1 -> O -> GAP2 -> S2 -> FIN -> IDLE.
- IDLE: on rise, go to S1 next cycle and set Busy=1. A rise in any other state is ignored and is not queued.
- S1 and S2: hold S_Start_Sig=1.
  - On the cycle S_Done_Sig=1 is sampled, clear S_Start_Sig at the next edge.
  - S1 then goes to GAP1; S2 then goes to FIN.
  - Start is therefore dropped exactly one cycle after done, so the generator returns to its idle step and does not replay.
- O: identical handshake using O_Start_Sig and O_Done_Sig; then go to GAP2.
- GAP1 and GAP2:
  - Both Start outputs are 0.
  - Prescaler counts 0..T1MS; the ms counter increments on prescaler==T1MS.
  - When the ms counter reaches GAP_MS, clear both counters and advance to the next state.
  - Gap length is exactly GAP_MS*(T1MS+1) cycles measured from state entry.
  - Both counters are cleared on entry to every gap state.
- FIN: Done_Sig=1 for one cycle, Busy=0 at the next edge, return to IDLE.
- Done pulses from the wrong generator, or outside a waiting state, are ignored.
- The two Start outputs are never high in the same cycle.
- Reset mid-sequence forces all reset values on the next edge. Start drops, so the generators finish their current step and then stall.
- Counter widths: prescaler 17 bits, ms counter 10 bits. No wrap is possible because each clears on its match.

Optional Feature:
- Macro: SOS_ABORT_EN.
- Defined: adds input Abort_Sig (1 bit).
  - Abort_Sig=1 in any non-IDLE state forces IDLE next edge.
  - Both Starts drop to 0, Busy drops to 0, counters clear.
  - No Done_Sig pulse is generated.
  - Abort_Sig has priority over a same-cycle done input.
- Undefined: the port is absent and every sequence runs to completion.

Test Plan (T1MS=9, GAP_MS=3; stub generators return done 20 cycles after their Start rises):
- Reset, then Trig rise at cycle 5 -> S_Start_Sig high from cycle 7. Full sequence shows S_Start, then 30-cycle gap, O_Start, 30-cycle gap, S_Start. Done_Sig pulses once; Busy falls one cycle later.
- Stub pulses S_Done_Sig at cycle k -> S_Start_Sig=0 at cycle k+1. O_Start_Sig stays 0 for exactly 30 cycles after the gap starts.
- Trig toggled 0->1->0->1 while Busy=1 -> no second sequence. Trig held high after finish -> no restart; a new 0->1 edge is required.
- O_Done_Sig injected during S1 and S_Done_Sig injected during O -> ignored, sequence unaffected.
- RSTn=1 during GAP1 for one cycle -> all outputs 0 next edge. A later Trig rise gives a normal full sequence.
- With SOS_ABORT_EN, Abort_Sig=1 in O state coincident with O_Done_Sig -> IDLE next edge, Busy=0, no Done_Sig, O_Start_Sig=0.
